amci_axi4lite_master: RTL and testbench

AXI4-Lite master engine on the slave side of the AMCI (AXI Master Control Interface). It takes the packed AMCI_MOSI bus driven by a controller, runs independent AXI4-Lite write and read transactions on an M_AXI port, and returns idle flags, response codes and read data on AMCI_MISO. One controller instance pairs with one engine instance.

---
 rtl/amci_axi4lite_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_amci_axi4lite_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amci_axi4lite_master.sv
// ---------------------------------------------------------------------------
// amci_axi4lite_master
//
// AXI4-Lite master engine behind an AMCI controller. The controller drives
// the packed AMCI_MOSI request bus. This block runs one AXI4-Lite write and
// one AXI4-Lite read at a time. The two run independently, so a write and a
// read can be in flight together. Idle flags, responses and read data go back
// on AMCI_MISO.
//
// Ports
//   CLK, RESETN      rising-edge clock; asynchronous active-low reset
//   AMCI_MOSI        packed LSB-first: WADDR, WDATA, RADDR, WRITE, READ
//   AMCI_MISO        packed LSB-first: RDATA, WIDLE, RIDLE, WRESP, RRESP
//   M_AXI_AW*/W*/B*  AXI4-Lite write address, write data and response
//   M_AXI_AR*/R*     AXI4-Lite read address and read data
//
// Every M_AXI output comes from a register. No combinational path runs from
// AMCI_MOSI to the AXI port.
// ---------------------------------------------------------------------------
module amci_axi4lite_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                       CLK,
  input  logic                                       RESETN,
  input  logic [2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+1:0] AMCI_MOSI,
  output logic [AXI_DATA_WIDTH+5:0]                  AMCI_MISO,
  output logic [AXI_ADDR_WIDTH-1:0]                  M_AXI_AWADDR,
  output logic [2:0]                                 M_AXI_AWPROT,
  output logic                                       M_AXI_AWVALID,
  input  logic                                       M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]                  M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]                M_AXI_WSTRB,
  output logic                                       M_AXI_WVALID,
  input  logic                                       M_AXI_WREADY,
  input  logic [1:0]                                 M_AXI_BRESP,
  input  logic                                       M_AXI_BVALID,
  output logic                                       M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]                  M_AXI_ARADDR,
  output logic [2:0]                                 M_AXI_ARPROT,
  output logic                                       M_AXI_ARVALID,
  input  logic                                       M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]                  M_AXI_RDATA,
  input  logic [1:0]                                 M_AXI_RRESP,
  input  logic                                       M_AXI_RVALID,
  output logic                                       M_AXI_RREADY
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;

  // The first member of a packed struct is the MSB, so these layouts give
  // the LSB-first AMCI field order.
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;
  } amci_req_t;

  typedef struct packed {
    logic [1:0]    rresp;
    logic [1:0]    wresp;
    logic          ridle;
    logic          widle;
    logic [DW-1:0] rdata;
  } amci_rsp_t;

  typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}      r_state_t;

  amci_req_t req;
  amci_rsp_t rsp;

  assign req       = AMCI_MOSI;
  assign AMCI_MISO = rsp;

  // ---------------------------------------------------------------- write
  w_state_t      w_state_q, w_state_d;
  logic          aw_valid_q, aw_valid_d;
  logic          w_valid_q, w_valid_d;
  logic          b_ready_q, b_ready_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [1:0]    w_resp_q, w_resp_d;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      w_state_q  <= W_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_resp_q   <= 2'b00;
    end else begin
      w_state_q  <= w_state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_resp_q   <= w_resp_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_resp_d   = w_resp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (req.wr) begin
          aw_addr_d  = req.waddr;
          w_data_d   = req.wdata;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          w_state_d  = W_ADDR_DATA;
        end
      end
      W_ADDR_DATA: begin
        // Each channel drops its VALID on its own handshake. Move on once
        // neither VALID will be high after this edge. That covers either
        // order and the case where both handshakes land on the same edge.
        aw_valid_d = aw_valid_q & ~M_AXI_AWREADY;
        w_valid_d  = w_valid_q & ~M_AXI_WREADY;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (M_AXI_BVALID && b_ready_q) begin
          w_resp_d  = M_AXI_BRESP;
          b_ready_d = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d  = W_IDLE;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        b_ready_d  = 1'b0;
      end
    endcase
  end

  // ----------------------------------------------------------------- read
  r_state_t      r_state_q, r_state_d;
  logic          ar_valid_q, ar_valid_d;
  logic          r_ready_q, r_ready_d;
  logic [AW-1:0] ar_addr_q, ar_addr_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic [1:0]    r_resp_q, r_resp_d;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state_q  <= R_IDLE;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      ar_addr_q  <= '0;
      r_data_q   <= '0;
      r_resp_q   <= 2'b00;
    end else begin
      r_state_q  <= r_state_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      ar_addr_q  <= ar_addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    ar_addr_d  = ar_addr_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (req.rd) begin
          ar_addr_d  = req.raddr;
          ar_valid_d = 1'b1;
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_valid_q && M_AXI_ARREADY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (M_AXI_RVALID && r_ready_q) begin
          r_data_d  = M_AXI_RDATA;
          r_resp_d  = M_AXI_RRESP;
          r_ready_d = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d  = R_IDLE;
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------- outputs
  // The idle flags decode the state register. A strobe in the cycle a flag
  // goes high is accepted on the next edge.
  always_comb begin
    rsp       = '0;
    rsp.rdata = r_data_q;
    rsp.widle = (w_state_q == W_IDLE);
    rsp.ridle = (r_state_q == R_IDLE);
    rsp.wresp = w_resp_q;
    rsp.rresp = r_resp_q;
  end

  assign M_AXI_AWADDR  = aw_addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_WDATA   = w_data_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_BREADY  = b_ready_q;
  assign M_AXI_ARADDR  = ar_addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_RREADY  = r_ready_q;

endmodule

// File: tb/tb_amci_axi4lite_master.sv
`timescale 1ns/1ps
module tb_amci_axi4lite_master;
  localparam int DW = 32;
  localparam int AW = 32;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  // AMCI side
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic          wr, rd;
  logic [2*AW+DW+1:0] mosi;
  logic [DW+5:0]      miso;
  logic [DW-1:0] rdata;
  logic          widle, ridle;
  logic [1:0]    wresp, rresp;
  assign mosi  = {rd, wr, raddr, wdata, waddr};
  assign rdata = miso[DW-1:0];
  assign widle = miso[DW];
  assign ridle = miso[DW+1];
  assign wresp = miso[DW+3:DW+2];
  assign rresp = miso[DW+5:DW+4];

  // AXI side
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  // slave behaviour knobs
  int aw_d, w_d, b_d, ar_d, r_d;
  logic [1:0]  b_rsp, r_rsp;
  logic [31:0] r_dat;

  amci_axi4lite_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESETN(RESETN), .AMCI_MOSI(mosi), .AMCI_MISO(miso),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready), .M_AXI_BRESP(b_rsp),
    .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready), .M_AXI_ARADDR(m_araddr),
    .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
    .M_AXI_RDATA(r_dat), .M_AXI_RRESP(r_rsp), .M_AXI_RVALID(m_rvalid),
    .M_AXI_RREADY(m_rready)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ AXI slave
  int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic p_awv, p_wv, p_arv;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [31:0] aw_log[$], w_log[$], ar_log[$];

  assign m_awready = m_awvalid && (aw_wait >= aw_d);
  assign m_wready  = m_wvalid  && (w_wait  >= w_d);
  assign m_arready = m_arvalid && (ar_wait >= ar_d);

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      aw_wait <= 0; w_wait <= 0; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      m_bvalid <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0;
    end else begin
      p_awv <= m_awvalid && !m_awready; p_awaddr <= m_awaddr;
      p_wv  <= m_wvalid && !m_wready;   p_wdata  <= m_wdata;
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_wait <= 0; aw_log.push_back(m_awaddr); end
      else if (m_awvalid) aw_wait <= aw_wait + 1;
      if (m_wvalid && m_wready) begin w_got <= 1'b1; w_wait <= 0; w_log.push_back(m_wdata); end
      else if (m_wvalid) w_wait <= w_wait + 1;
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end else if (!m_bvalid && (aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
        if (b_cnt >= b_d) m_bvalid <= 1'b1; else b_cnt <= b_cnt + 1;
      end
    end
  end

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ar_wait <= 0; r_cnt <= 0; ar_got <= 1'b0; m_rvalid <= 1'b0; p_arv <= 1'b0;
    end else begin
      p_arv <= m_arvalid && !m_arready; p_araddr <= m_araddr;
      if (m_arvalid && m_arready) begin ar_got <= 1'b1; ar_wait <= 0; ar_log.push_back(m_araddr); end
      else if (m_arvalid) ar_wait <= ar_wait + 1;
      if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
      end else if (!m_rvalid && (ar_got || (m_arvalid && m_arready))) begin
        if (r_cnt >= r_d) m_rvalid <= 1'b1; else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Protocol monitor: a stalled VALID must stay up with stable payload, and
  // BREADY must not rise until both write beats are gone.
  always @(negedge CLK) begin
    if (RESETN) begin
      if (p_awv) chk("aw_hold", {m_awvalid, m_awaddr}, {1'b1, p_awaddr});
      if (p_wv)  chk("w_hold",  {m_wvalid, m_wdata},   {1'b1, p_wdata});
      if (p_arv) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, p_araddr});
      if (m_bready) chk("bready_after_both", {m_awvalid, m_wvalid}, 2'b00);
      if (m_wvalid && m_wready) chk("wstrb", m_wstrb, 4'hF);
    end
  end

  // -------------------------------------------------------------- helpers
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic set_cfg(input int a, input int w, input int b, input int ar, input int r);
    aw_d = a; w_d = w; b_d = b; ar_d = ar; r_d = r;
  endtask

  task automatic clr_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete();
  endtask

  // One strobe cycle, then scramble the request fields to prove latching.
  task automatic strobe(input logic dw, input logic dr, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [31:0] ra);
    waddr = wa; wdata = wd; raddr = ra; wr = dw; rd = dr;
    step();
    wr = 1'b0; rd = 1'b0;
    waddr = $urandom; wdata = $urandom; raddr = $urandom;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(widle && ridle) && n < budget) begin step(); n++; end
    chk({nm, "_idle"}, {widle, ridle}, 2'b11);
  endtask

  function automatic logic [31:0] q0(input logic [31:0] q[$]);
    return (q.size() > 0) ? q[0] : 32'hxxxx_xxxx;
  endfunction

  // --------------------------------------------------------------- vectors
  typedef struct {
    logic [31:0] waddr, wdata, raddr, rdata;
    logic [1:0]  bresp, rresp;
    int          awd, wd, bd, ard, rdl;
    logic [31:0] exp_awaddr, exp_wdata, exp_araddr, exp_rdata;
    logic [1:0]  exp_wresp, exp_rresp;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] wa, input logic [31:0] wd,
                              input logic [31:0] ra, input logic [31:0] rdv,
                              input logic [1:0] br, input logic [1:0] rr,
                              input int awd, input int wdl, input int bd,
                              input int ard, input int rdl);
    vec_t v;
    v.waddr = wa; v.wdata = wd; v.raddr = ra; v.rdata = rdv; v.bresp = br; v.rresp = rr;
    v.awd = awd; v.wd = wdl; v.bd = bd; v.ard = ard; v.rdl = rdl;
    v.exp_awaddr = wa; v.exp_wdata = wd; v.exp_araddr = ra; v.exp_rdata = rdv;
    v.exp_wresp = br; v.exp_rresp = rr;
    return v;
  endfunction

  vec_t vt[7];
  logic [1:0]  m_wresp, m_rresp;
  logic [31:0] m_rdata;

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vt[0] = mk(32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0BAD_F00D, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    vt[1] = mk(32'h0000_0010, 32'h0000_0001, 32'h0000_2004, 32'h1234_5678, 2'b00, 2'b10, 0, 0, 0, 4, 0);
    vt[2] = mk(32'h0000_3000, 32'hA5A5_0001, 32'h0000_3004, 32'h5A5A_0001, 2'b01, 2'b00, 3, 0, 0, 0, 2);
    vt[3] = mk(32'h0000_3008, 32'hA5A5_0002, 32'h0000_300C, 32'h5A5A_0002, 2'b00, 2'b01, 0, 3, 1, 1, 0);
    vt[4] = mk(32'h0000_3010, 32'hA5A5_0003, 32'h0000_3014, 32'h5A5A_0003, 2'b10, 2'b11, 2, 2, 0, 0, 0);
    vt[5] = mk(32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 2'b11, 2'b10, 0, 0, 10, 0, 0);
    vt[6] = mk(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001, 2'b10, 2'b11, 1, 4, 3, 2, 5);

    wr = 0; rd = 0; waddr = 0; wdata = 0; raddr = 0;
    set_cfg(0, 0, 0, 0, 0); b_rsp = 2'b00; r_rsp = 2'b00; r_dat = 32'h0;

    // reset state
    repeat (3) @(posedge CLK); #1;
    chk("rst_valid_ready", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk("rst_miso", miso, {2'b00, 2'b00, 1'b1, 1'b1, 32'h0});
    chk("rst_addr_data", {m_awaddr, m_wdata, m_araddr}, 96'h0);
    chk("rst_prot_strb", {m_awprot, m_arprot, m_wstrb}, {6'b0, 4'hF});
    RESETN = 1'b1;
    step();

    // strobe-to-idle latency, slave always ready
    r_dat = 32'hCAFE_0001;
    strobe(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_3000);
    chk("lat1_w", {widle, m_awvalid, m_wvalid, m_bready}, 4'b0110);
    chk("lat1_payload", {m_awaddr, m_wdata, m_wstrb}, {32'h0000_1000, 32'hDEAD_BEEF, 4'hF});
    chk("lat1_r", {ridle, m_arvalid, m_rready, m_araddr}, {3'b010, 32'h0000_3000});
    step();
    chk("lat2_w", {widle, m_awvalid, m_wvalid, m_bready}, 4'b0001);
    chk("lat2_r", {ridle, m_arvalid, m_rready}, 3'b001);
    step();
    chk("lat3_w", {widle, m_bready, wresp}, {2'b10, 2'b00});
    chk("lat3_r", {ridle, m_rready, rdata}, {2'b10, 32'hCAFE_0001});

    // table: write and read strobed together each time
    for (int i = 0; i < 7; i++) begin
      set_cfg(vt[i].awd, vt[i].wd, vt[i].bd, vt[i].ard, vt[i].rdl);
      b_rsp = vt[i].bresp; r_rsp = vt[i].rresp; r_dat = vt[i].rdata;
      clr_logs();
      strobe(1'b1, 1'b1, vt[i].waddr, vt[i].wdata, vt[i].raddr);
      wait_idle($sformatf("vec%0d", i), 200);
      chk($sformatf("vec%0d_wresp", i), wresp, vt[i].exp_wresp);
      chk($sformatf("vec%0d_rresp", i), rresp, vt[i].exp_rresp);
      chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_beats", i), {aw_log.size(), w_log.size(), ar_log.size()}, {32'd1, 32'd1, 32'd1});
      chk($sformatf("vec%0d_awaddr", i), q0(aw_log), vt[i].exp_awaddr);
      chk($sformatf("vec%0d_wdata", i), q0(w_log), vt[i].exp_wdata);
      chk($sformatf("vec%0d_araddr", i), q0(ar_log), vt[i].exp_araddr);
    end

    // ARREADY held off 4 cycles: ARVALID up for 5 cycles
    begin
      int cnt = 0;
      set_cfg(0, 0, 0, 4, 0); r_dat = 32'h1234_5678; r_rsp = 2'b10; clr_logs();
      strobe(1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_2004);
      while (m_arvalid && cnt < 50) begin cnt++; step(); end
      chk("arvalid_cycles", cnt, 5);
      cnt = 0;
      while (!ridle && cnt < 50) begin cnt++; step(); end
      chk("rd_at_ridle", {ridle, rdata, rresp}, {1'b1, 32'h1234_5678, 2'b10});
      chk("rd_araddr", q0(ar_log), 32'h0000_2004);
    end

    // busy strobe ignored; strobe in the idle-return cycle accepted
    begin
      int cnt = 0;
      set_cfg(0, 0, 5, 0, 0); b_rsp = 2'b00; clr_logs();
      strobe(1'b1, 1'b0, 32'h0000_4000, 32'h0000_0011, 32'h0);
      step();
      chk("busy_widle", widle, 1'b0);
      strobe(1'b1, 1'b0, 32'h0000_4444, 32'h0000_0022, 32'h0);
      while (!widle && cnt < 50) begin cnt++; step(); end
      chk("busy_beats", {aw_log.size(), w_log.size()}, {32'd1, 32'd1});
      chk("busy_awaddr", q0(aw_log), 32'h0000_4000);
      set_cfg(0, 0, 0, 0, 0);
      strobe(1'b1, 1'b0, 32'h0000_5000, 32'h0000_0033, 32'h0);
      chk("idle_edge_accept", {widle, m_awvalid, m_awaddr}, {2'b01, 32'h0000_5000});
      wait_idle("idle_edge", 50);
      chk("idle_edge_beats", aw_log.size(), 2);
      chk("idle_edge_wdata", (w_log.size() > 1) ? w_log[1] : 32'hxxxx_xxxx, 32'h0000_0033);
    end

    // concurrent: slow B must not hold up the read
    begin
      int cnt = 0;
      set_cfg(0, 0, 10, 0, 0); b_rsp = 2'b01; r_rsp = 2'b00; r_dat = 32'h7777_0000;
      strobe(1'b1, 1'b1, 32'h0000_6000, 32'h0000_0044, 32'h0000_6004);
      while (!ridle && cnt < 50) begin cnt++; step(); end
      chk("conc_read_first", {ridle, widle, rdata, rresp}, {2'b10, 32'h7777_0000, 2'b00});
      wait_idle("conc", 50);
      chk("conc_wresp", wresp, 2'b01);
    end

    // reset in W_RESP / R_ADDR after a completion left non-zero results
    set_cfg(0, 0, 0, 0, 0); b_rsp = 2'b11; r_rsp = 2'b01; r_dat = 32'hABCD_1234;
    strobe(1'b1, 1'b1, 32'h0000_7000, 32'h0000_0055, 32'h0000_7004);
    wait_idle("pre_rst", 50);
    chk("pre_rst_miso", {wresp, rresp, rdata}, {2'b11, 2'b01, 32'hABCD_1234});
    set_cfg(0, 0, 20, 20, 0);
    strobe(1'b1, 1'b1, 32'h0000_8000, 32'h0000_0066, 32'h0000_8004);
    step();
    chk("pre_rst_states", {m_bready, m_arvalid}, 2'b11);
    #2 RESETN = 1'b0;
    #1;
    chk("rst_mid_valid_ready", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk("rst_mid_miso", miso, {2'b00, 2'b00, 1'b1, 1'b1, 32'h0});
    chk("rst_mid_addr", {m_awaddr, m_wdata, m_araddr}, 96'h0);
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
    step();
    clr_logs();

    // random: reference model holds the last reported result per channel
    m_wresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
    for (int it = 0; it < 40; it++) begin
      int kind;
      logic dw, dr;
      logic [31:0] wa, wd, ra;
      kind = $urandom_range(1, 3);
      dw = kind[0]; dr = kind[1];
      set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4));
      b_rsp = 2'($urandom); r_rsp = 2'($urandom); r_dat = $urandom;
      wa = $urandom; wd = $urandom; ra = $urandom;
      clr_logs();
      strobe(dw, dr, wa, wd, ra);
      if (dw) m_wresp = b_rsp;
      if (dr) begin m_rresp = r_rsp; m_rdata = r_dat; end
      wait_idle($sformatf("rnd%0d", it), 100);
      chk($sformatf("rnd%0d_resp", it), {wresp, rresp, rdata}, {m_wresp, m_rresp, m_rdata});
      chk($sformatf("rnd%0d_beats", it), {aw_log.size(), w_log.size(), ar_log.size()},
          {32'(dw), 32'(dw), 32'(dr)});
      if (dw) chk($sformatf("rnd%0d_wr", it), {q0(aw_log), q0(w_log)}, {wa, wd});
      if (dr) chk($sformatf("rnd%0d_ar", it), q0(ar_log), ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
